uart_rx: RTL and testbench

//  UART receiver, 8N1, LSB first; the receive-side counterpart of uart_tx.
//  - Same CLK_FREQ/BAUD_RATE parameters as uart_tx, so the two can be looped back.
//  - Synchronises the asynchronous serial line and validates the start bit.
//  - Samples each bit at mid-period and checks the stop bit.
//  - Presents each received byte with a 1-cycle valid strobe, or a 1-cycle framing-error strobe.

---
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. Synchronises rx, qualifies the start bit at half-bit,
// samples data and stop at bit centres, and emits a 1-cycle valid or framing-error strobe.
module uart_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int BAUD_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PERIOD = BAUD_PERIOD / 2;
    localparam int CNT_W       = $clog2(BAUD_PERIOD);

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BAUD_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic             rx_meta_r;
    logic             rx_s_r;
    logic             rx_prev_r;
    state_t           state_r;
    state_t           state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_nx_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nx_s;
    logic [7:0]       rx_data_r;
    logic [7:0]       rx_data_nx_s;
    logic             rx_valid_r;
    logic             rx_valid_nx_s;
    logic             frame_err_r;
    logic             frame_err_nx_s;
    logic             rx_busy_r;
    logic             rx_busy_nx_s;
    logic             fall_s;

    assign fall_s = rx_prev_r & ~rx_s_r;

    // Synchroniser and edge-detect history; preset high so reset looks like an idle line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_r <= 1'b1;
            rx_s_r    <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s_r    <= rx_meta_r;
            rx_prev_r <= rx_s_r;
        end
    end

    // Receiver state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            rx_busy_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            bit_idx_r   <= bit_idx_nx_s;
            shift_r     <= shift_nx_s;
            rx_data_r   <= rx_data_nx_s;
            rx_valid_r  <= rx_valid_nx_s;
            frame_err_r <= frame_err_nx_s;
            rx_busy_r   <= rx_busy_nx_s;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nx_s     = state_r;
        cnt_nx_s       = cnt_r;
        bit_idx_nx_s   = bit_idx_r;
        shift_nx_s     = shift_r;
        rx_data_nx_s   = rx_data_r;
        rx_valid_nx_s  = 1'b0;
        frame_err_nx_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Only a genuine 1->0 edge arms; a line stuck low after a break does not.
                if (fall_s) begin
                    state_nx_s = ST_START;
                    cnt_nx_s   = CNT_ZERO;
                end else begin
                    cnt_nx_s   = CNT_ZERO;
                end
            end
            ST_START: begin
                if (cnt_r == CNT_HALF_END) begin
                    cnt_nx_s = CNT_ZERO;
                    if (rx_s_r) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s   = ST_DATA;
                        bit_idx_nx_s = 3'd0;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_BIT_END) begin
                    cnt_nx_s   = CNT_ZERO;
                    shift_nx_s = {rx_s_r, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_nx_s = ST_STOP;
                    end else begin
                        bit_idx_nx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
                if (cnt_r == CNT_BIT_END) begin
                    cnt_nx_s   = CNT_ZERO;
                    state_nx_s = ST_IDLE;
                    if (rx_s_r) begin
                        rx_data_nx_s  = shift_r;
                        rx_valid_nx_s = 1'b1;
                    end else begin
                        frame_err_nx_s = 1'b1;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = CNT_ZERO;
            end
        endcase
        rx_busy_nx_s = (state_nx_s != ST_IDLE);
    end

    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;
    assign rx_busy   = rx_busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-banged frames (directed and random) against a
// frame-level model of expected bytes, framing errors, latency and busy duration.
module tb_uart_rx;

    localparam int CLK_FREQ  = 3200000;
    localparam int BAUD_RATE = 100000;
    localparam int BP        = CLK_FREQ / BAUD_RATE;
    localparam int HALF      = BP / 2;
    localparam int LAT       = 2 + HALF + 9 * BP;
    localparam int BUSY_LEN  = HALF + 9 * BP;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    logic [7:0] got_q[$];
    int         lat_q[$];
    int         ferr_cnt = 0;
    int         viol = 0;
    int         busy_run = 0;
    int         busy_last = 0;
    logic       pulse_prev = 1'b0;

    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    logic [7:0] exp_data = 8'h00;

    // Output monitor, sampled 1 ns after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (reset_n) begin
            if (rx_valid) begin
                got_q.push_back(rx_data);
                lat_q.push_back(cyc - start_cyc);
            end
            if (frame_err) ferr_cnt = ferr_cnt + 1;
            if (rx_valid && frame_err) viol = viol + 1;
            if ((rx_valid || frame_err) && pulse_prev) viol = viol + 1;
            pulse_prev = rx_valid | frame_err;
            if (rx_busy) begin
                busy_run = busy_run + 1;
            end else if (busy_run != 0) begin
                busy_last = busy_run;
                busy_run  = 0;
            end
        end else begin
            pulse_prev = 1'b0;
            busy_run   = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Drives start, 8 data bits LSB first, and the given stop level; leaves rx at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        start_cyc = cyc;
        hold(1'b0, BP);
        for (int i = 0; i < 8; i++) hold(b[i], BP);
        hold(stop_bit, BP);
    endtask

    // Frame-level reference: a good stop delivers the byte, a bad one only counts an error.
    task automatic model_frame(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) begin
            exp_q.push_back(b);
            exp_data = b;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
        check({tag, "_data"}, rx_data, exp_data);
    endtask

    initial begin
        logic [7:0] b;
        logic       sb;
        int         gap;
        int         n_good;

        rx      = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data", rx_data, 8'h00);
        check("reset_pulses", {rx_valid, frame_err, rx_busy}, 3'b000);
        reset_n = 1'b1;
        hold(1'b1, 8);

        // 1: single byte, plus busy duration
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1);
        hold(1'b1, 4);
        check_state("t1");
        check_range("t1_busy_len", busy_last, BUSY_LEN - 2, BUSY_LEN + 2);

        // 2: back-to-back bytes
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1);
        hold(1'b1, 4);
        check_state("t2");

        // 3: glitch shorter than half a bit
        hold(1'b0, 6);
        check("t3_busy_during", rx_busy, 1'b1);
        hold(1'b1, HALF + 4);
        check("t3_busy_after", rx_busy, 1'b0);
        check_state("t3");

        // 4: bad stop bit followed by a long break
        send_frame(8'h55, 1'b0);
        model_frame(8'h55, 1'b0);
        hold(1'b0, 4 * BP);
        check("t4_busy_break", rx_busy, 1'b0);
        check_state("t4");
        hold(1'b1, 8);
        send_frame(8'hC3, 1'b1);
        model_frame(8'hC3, 1'b1);
        hold(1'b1, 4);
        check_state("t4_recover");

        // 5: reset mid-frame
        start_cyc = cyc;
        hold(1'b0, BP);
        hold(1'b1, 3 * BP + 5);
        reset_n = 1'b0;
        #1;
        check("t5_reset_data", rx_data, 8'h00);
        check("t5_reset_pulses", {rx_valid, frame_err, rx_busy}, 3'b000);
        exp_data = 8'h00;
        hold(1'b1, 3);
        reset_n = 1'b1;
        hold(1'b1, 6 * BP);
        check_state("t5_idle");
        send_frame(8'h0F, 1'b1);
        model_frame(8'h0F, 1'b1);
        hold(1'b1, 4);
        check_state("t5");

        // 6: stream of bytes as a transmitter would send them
        send_frame(8'h00, 1'b1); model_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1); model_frame(8'hFF, 1'b1);
        send_frame(8'hA5, 1'b1); model_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1); model_frame(8'h3C, 1'b1);
        hold(1'b1, 4);
        check_state("t6");

        // random frames, gaps and stop-bit errors
        for (int k = 0; k < 12; k++) begin
            b   = 8'($urandom_range(0, 255));
            sb  = ($urandom_range(0, 3) != 0);
            gap = sb ? $urandom_range(0, BP) : 4 + $urandom_range(0, BP);
            send_frame(b, sb);
            model_frame(b, sb);
            check_state($sformatf("rnd%0d", k));
            hold(1'b1, gap);
        end
        hold(1'b1, 4);

        n_good = exp_q.size();
        check("final_count", got_q.size(), n_good);
        for (int i = 0; i < n_good && i < got_q.size(); i++) begin
            check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
            check_range($sformatf("lat%0d", i), lat_q[i], LAT - 2, LAT + 2);
        end
        check("pulse_protocol", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
